// File: rtl/cla_multiword_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial carry-look-ahead adder.
// Optional subtract support is selected with the CLA_SEQ_SUB_EN macro.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  // 2'd3 is unused and decodes to IDLE behaviour in the top-level FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_multiword_seq_if.sv
// Operand/result handshake bundle for cla_multiword_seq.
// The in_sub member exists only when CLA_SEQ_SUB_EN is defined.
interface cla_multiword_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
`ifdef CLA_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         busy;

  modport master (
`ifdef CLA_SEQ_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
`ifdef CLA_SEQ_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/cla_multiword_seq_cla4_slice.sv
// Combinational 4-bit carry-look-ahead slice: every carry is a flat function of
// generate/propagate terms and carry-in, with no internal ripple.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1, c2, c3;

  assign p = a ^ b;
  assign g = a & b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide adder that walks one shared 4-bit CLA slice across the operands, LSB nibble first.
// Defining CLA_SEQ_SUB_EN adds the in_sub port for two's-complement A-B.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                clock,
  input logic                reset,
  cla_multiword_seq_if.slave bus
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_p0, b_p0;
  logic [W:0]       sum_p0;
  logic             vld_p0;

  logic             accept, last, in_ready, busy, sub;
  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_cout;

`ifdef CLA_SEQ_SUB_EN
  assign sub = bus.in_sub;
`else
  assign sub = 1'b0;
`endif

  assign last    = (idx_q == IDX_W'(NIBBLES - 1));
  assign slice_a = a_p0[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = b_p0[SLICE_W*idx_q +: SLICE_W];

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  // Stage p0: operand capture; subtraction folds into inverted B plus carry-in of 1.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_p0 <= bus.in_a;
      b_p0 <= sub ? ~bus.in_b : bus.in_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_p0  <= '0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RUN: begin
          sum_p0[SLICE_W*idx_q +: SLICE_W] <= slice_s;
          carry_q <= slice_cout;
          if (last) begin
            sum_p0[W] <= slice_cout;
            vld_p0    <= 1'b1;
            idx_q     <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) vld_p0 <= 1'b0;
        end
        default: begin
          if (accept) begin
            idx_q   <= '0;
            carry_q <= sub;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = vld_p0;
  assign bus.out_sum   = sum_p0;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for cla_multiword_seq with an expected-result queue filled at accept time.
module tb_cla_multiword_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cla_multiword_seq_if #(.NIBBLES(NIBBLES)) bus_if ();

  cla_multiword_seq #(.NIBBLES(NIBBLES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus_if.in_a = a;
    bus_if.in_b = b;
`ifdef CLA_SEQ_SUB_EN
    bus_if.in_sub = sub;
`endif
  endtask

  // Drives operands at a falling edge, takes the accepting rising edge, then drops in_valid.
  task automatic accept_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input bit push);
    @(negedge clock);
    check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    drive_ops(a, b, sub);
    bus_if.in_valid = 1'b1;
    if (push) exp_q.push_back(model(a, b, sub));
    @(posedge clock);
    #1 bus_if.in_valid = 1'b0;
  endtask

  // Waits for out_valid after an accept edge and checks latency and the queued result.
  task automatic wait_result(input string tag);
    int lat;
    logic [W:0] exp;
    lat = 0;
    forever begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (bus_if.out_valid === 1'b1) break;
      if (lat == 1) check({tag, "_run_in_ready"}, 32'(bus_if.in_ready), 32'd0);
      if (lat > 20) begin
        check({tag, "_timeout"}, 32'(lat), 32'(NIBBLES));
        return;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_sum"}, 32'(bus_if.out_sum), 32'(exp));
  endtask

  task automatic consume(input string tag);
    bus_if.out_ready = 1'b1;
    @(posedge clock);
    #1 bus_if.out_ready = 1'b0;
    @(negedge clock);
    check({tag, "_done_valid"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    drive_ops('0, '0, 1'b0);

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_out_sum", 32'(bus_if.out_sum), 32'd0);
    reset = 1'b0;

    // 1: basic add
    accept_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_result("t1");
    check("t1_const", 32'(bus_if.out_sum), 32'h0_5555);
    consume("t1");

    // 2: carry ripple through all slices
    accept_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_result("t2");
    check("t2_const", 32'(bus_if.out_sum), 32'h1_0000);
    consume("t2");

    // 3: consumer stalls for 3 cycles
    accept_op("t3", 16'h8000, 16'h8000, 1'b0, 1'b1);
    wait_result("t3");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t3_hold_sum", 32'(bus_if.out_sum), 32'h1_0000);
      check("t3_hold_ready", 32'(bus_if.in_ready), 32'd0);
      check("t3_hold_valid", 32'(bus_if.out_valid), 32'd1);
    end
    consume("t3");

    // 4: reset mid-operation at idx=2
    accept_op("t4", 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t4_rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("t4_rst_ready", 32'(bus_if.in_ready), 32'd1);
    check("t4_rst_busy", 32'(bus_if.busy), 32'd0);
    accept_op("t4b", 16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_result("t4b");
    check("t4b_const", 32'(bus_if.out_sum), 32'h0_0002);
    consume("t4b");

    // 5: in_valid held with new operands while busy
    @(negedge clock);
    drive_ops(16'h0F0F, 16'h00F1, 1'b0);
    bus_if.in_valid = 1'b1;
    exp_q.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
    @(posedge clock);
    #1 drive_ops(16'h1111, 16'h2222, 1'b0);
    wait_result("t5a");
    bus_if.out_ready = 1'b1;
    @(posedge clock);
    #1 bus_if.out_ready = 1'b0;
    @(negedge clock);
    check("t5_idle_ready", 32'(bus_if.in_ready), 32'd1);
    check("t5_idle_busy", 32'(bus_if.busy), 32'd0);
    @(posedge clock);
    #1 bus_if.in_valid = 1'b0;
    wait_result("t5b");
    check("t5b_const", 32'(bus_if.out_sum), 32'h0_3333);
    consume("t5b");

    // Full-scale add: maximum carry-out
    accept_op("tmax", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_result("tmax");
    consume("tmax");

`ifdef CLA_SEQ_SUB_EN
    // 6: subtraction with and without borrow
    accept_op("t6a", 16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result("t6a");
    check("t6a_const", 32'(bus_if.out_sum), 32'h0_FFFE);
    consume("t6a");
    accept_op("t6b", 16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_result("t6b");
    check("t6b_const", 32'(bus_if.out_sum), 32'h1_0002);
    consume("t6b");
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
